// File: rtl/fft_mag_unload.sv
// ---------------------------------------------------------------------------
// fft_mag_unload
//
// Sits downstream of the FFT core. When the core pulses fft_finish, the whole
// parallel result bus is captured into a frame register. The bins are then
// streamed one per beat over a valid/ready handshake. Each beat carries an
// alpha-max-beta-min magnitude estimate, |z| ~ max(|re|,|im|) + min(|re|,|im|)/2,
// and the bin index. The largest magnitude in each frame, and the bin where it
// occurs, are published with a one-cycle peak_valid pulse after the frame.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   fft_data     in   MSB*N frame bus, word w at [MSB*w +: MSB]
//                     (upper MSB/2 bits = signed re, lower MSB/2 bits = signed im)
//   fft_finish   in   one-cycle pulse, fft_data valid in the same cycle
//   frame_ready  out  high only while idle (a frame would be accepted)
//   out_valid    out  stream beat valid
//   out_ready    in   downstream accept
//   out_mag      out  MSB/2+1 bit unsigned magnitude estimate
//   out_bin      out  bin index of the current beat
//   out_last     out  high on the final bin of the frame
//   peak_valid   out  one-cycle pulse after the frame completes
//   peak_bin     out  index of the largest magnitude in the last frame
//   peak_mag     out  that magnitude
//   overrun      out  sticky: fft_finish seen while not idle
// ---------------------------------------------------------------------------
module fft_mag_unload #(
    parameter int N      = 16,
    parameter int MSB    = 16,
    parameter int HALF   = 1,
    parameter int BITREV = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [MSB*N-1:0]       fft_data,
    input  logic                   fft_finish,
    output logic                   frame_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MSB/2:0]         out_mag,
    output logic [$clog2(N)-1:0]   out_bin,
    output logic                   out_last,
    output logic                   peak_valid,
    output logic [$clog2(N)-1:0]   peak_bin,
    output logic [MSB/2:0]         peak_mag,
    output logic                   overrun
);

    localparam int W     = MSB / 2;
    localparam int LOG2N = $clog2(N);
    localparam int B     = (HALF != 0) ? (N / 2) : N;
    localparam logic [LOG2N-1:0] LAST_BIN = LOG2N'(B - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Frame storage and stream output registers
    logic [MSB*N-1:0] r_frame;
    logic             r_valid;
    logic [W:0]       r_mag;
    logic [LOG2N-1:0] r_bin;
    logic             r_last;

    // Running peak for the frame in flight, and the published peak
    logic [W:0]       r_run_mag;
    logic [LOG2N-1:0] r_run_bin;
    logic             r_peak_valid;
    logic [W:0]       r_peak_mag;
    logic [LOG2N-1:0] r_peak_bin;
    logic             r_overrun;

    // ------------------------------------------------------------------
    // Word selection for the bin about to be loaded into the output regs
    // ------------------------------------------------------------------
    logic [MSB-1:0]   w_word [N];
    logic [LOG2N-1:0] w_sel_bin;
    logic [LOG2N-1:0] w_sel_rev;
    logic [LOG2N-1:0] w_sel_word;
    logic [MSB-1:0]   w_sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_word[gi] = r_frame[MSB*gi +: MSB];
        end
        for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
            assign w_sel_rev[gi] = w_sel_bin[LOG2N-1-gi];
        end
    endgenerate

    // LOAD always presents bin 0; in STREAM the output register holds the
    // current bin, so the one to load on acceptance is the next one.
    assign w_sel_bin  = (r_state == S_LOAD) ? '0 : (r_bin + 1'b1);
    assign w_sel_word = (BITREV != 0) ? w_sel_rev : w_sel_bin;
    assign w_sel_data = w_word[w_sel_word];

    // ------------------------------------------------------------------
    // Alpha-max-beta-min magnitude
    // ------------------------------------------------------------------
    // Magnitude of a W-bit signed value as W-bit unsigned. The most
    // negative value maps to 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v[W-1] ? (~v + 1'b1) : v;
        return r;
    endfunction

    logic [W-1:0] w_re;
    logic [W-1:0] w_im;
    logic [W-1:0] w_abs_re;
    logic [W-1:0] w_abs_im;
    logic [W-1:0] w_max;
    logic [W-1:0] w_min;
    logic [W-1:0] w_min_half;
    logic [W:0]   w_mag;

    assign w_re       = w_sel_data[MSB-1:W];
    assign w_im       = w_sel_data[W-1:0];
    assign w_abs_re   = abs_w(w_re);
    assign w_abs_im   = abs_w(w_im);
    assign w_max      = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
    assign w_min      = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
    assign w_min_half = w_min >> 1;
    // max <= 2^(W-1) and min/2 <= 2^(W-2), so W+1 bits cannot overflow.
    assign w_mag      = {1'b0, w_max} + {1'b0, w_min_half};

    // ------------------------------------------------------------------
    // Handshake and peak compare
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_beats_peak;

    assign w_accept     = r_valid & out_ready;
    // Strict greater-than: ties keep the lower (earlier) bin.
    assign w_beats_peak = (r_mag > r_run_mag);

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (fft_finish) w_state_next = S_LOAD;
            S_LOAD:   w_state_next = S_STREAM;
            S_STREAM: if (w_accept && r_last) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame      <= '0;
            r_valid      <= 1'b0;
            r_mag        <= '0;
            r_bin        <= '0;
            r_last       <= 1'b0;
            r_run_mag    <= '0;
            r_run_bin    <= '0;
            r_peak_valid <= 1'b0;
            r_peak_mag   <= '0;
            r_peak_bin   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_peak_valid <= 1'b0;

            // A finish pulse outside IDLE (including the DONE->IDLE cycle)
            // is dropped; the frame register is left untouched.
            if (fft_finish && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (fft_finish) begin
                        r_frame   <= fft_data;
                        r_bin     <= '0;
                        r_run_mag <= '0;
                        r_run_bin <= '0;
                    end
                end

                S_LOAD: begin
                    r_valid <= 1'b1;
                    r_mag   <= w_mag;
                    r_bin   <= w_sel_bin;
                    r_last  <= (w_sel_bin == LAST_BIN);
                end

                S_STREAM: begin
                    if (w_accept) begin
                        if (w_beats_peak) begin
                            r_run_mag <= r_mag;
                            r_run_bin <= r_bin;
                        end
                        if (r_last) begin
                            // Publish the peak including this final beat so
                            // the values are already valid during DONE.
                            r_valid      <= 1'b0;
                            r_peak_valid <= 1'b1;
                            r_peak_mag   <= w_beats_peak ? r_mag : r_run_mag;
                            r_peak_bin   <= w_beats_peak ? r_bin : r_run_bin;
                        end else begin
                            // Zero-bubble advance to the next bin.
                            r_mag  <= w_mag;
                            r_bin  <= w_sel_bin;
                            r_last <= (w_sel_bin == LAST_BIN);
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign frame_ready = (r_state == S_IDLE);
    assign out_valid   = r_valid;
    assign out_mag     = r_mag;
    assign out_bin     = r_bin;
    assign out_last    = r_last;
    assign peak_valid  = r_peak_valid;
    assign peak_bin    = r_peak_bin;
    assign peak_mag    = r_peak_mag;
    assign overrun     = r_overrun;

endmodule

// File: doc/fft_mag_unload.md
Name: fft_mag_unload

Overview:
- Downstream consumer of the FFT core's parallel result bus.
- On the core's finish pulse it latches the whole frame, then streams one bin per beat over a valid/ready handshake.
- Each beat carries an alpha-max-beta-min magnitude estimate and the bin index.
- Tracks the peak bin of each frame, so spectrum readout and the peak detector need no access to the wide bus.

Parameters:
- N, 16, FFT length (power of 2, ≥4); number of words on fft_data.
- MSB, 16, bits per complex word (even); upper MSB/2 = signed real, lower MSB/2 = signed imag.
- HALF, 1, 1 = stream bins 0..N/2-1 only; 0 = stream bins 0..N-1.
- BITREV, 0, 1 = bin k read from word bitrev(k) (log2(N) bits); 0 = bin k read from word k.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-high; clears all state.
- fft_data, in, MSB*N, frame bus; word w at bits [MSB*w +: MSB].
- fft_finish, in, 1, one-cycle pulse; fft_data valid in the same cycle.
- frame_ready, out, 1, high only in IDLE (a frame would be accepted).
- out_valid, out, 1, stream beat valid.
- out_ready, in, 1, downstream accept.
- out_mag, out, MSB/2+1, unsigned magnitude estimate.
- out_bin, out, log2(N), bin index of current beat.
- out_last, out, 1, high on final bin of frame.
- peak_valid, out, 1, one-cycle pulse after frame completes.
- peak_bin, out, log2(N), index of largest magnitude in last completed frame.
- peak_mag, out, MSB/2+1, that magnitude.
- overrun, out, 1, sticky: fft_finish seen while not IDLE.

Behaviour:
- Reset values: all outputs 0 except frame_ready=1 (state IDLE); frame register, counters and peak tracking cleared. Reset mid-stream aborts the frame with no further beats.
- Let W=MSB/2 and B = N/2 if HALF else N.
- Magnitude: a=|re|, b=|im| as W-bit unsigned (|-2^(W-1)| = 2^(W-1)); mag = max(a,b) + (min(a,b)>>1), W+1 bits, no overflow possible.
- IDLE:
  - fft_finish=1 at edge T: latch fft_data into frame register, bin counter=0, running peak cleared, → LOAD.
  - Otherwise hold.
- LOAD (one cycle): registers out_mag/out_bin/out_last for bin 0, out_valid=1 after this edge, → STREAM. Result: first beat valid at edge T+2.
- STREAM:
  - Outputs held stable while out_valid & ~out_ready.
  - On out_valid & out_ready, the running peak updates with strict greater-than, so ties keep the lower bin and an all-zero frame gives peak_bin=0, peak_mag=0.
  - If out_last: out_valid=0, → DONE.
  - Else the next bin loads into the output registers on the same edge (zero bubble, 1 beat/clk at full ready).
- out_last=1 exactly when out_bin=B-1.
- DONE (one cycle): peak_bin/peak_mag updated from the running peak, peak_valid=1 for this cycle only, → IDLE. peak_bin/peak_mag hold until the next DONE.
- fft_finish while in LOAD, STREAM or DONE: frame ignored (frame register untouched), overrun←1 and stays set until reset.
- fft_finish in the same cycle DONE→IDLE: ignored and flagged overrun (state is not IDLE at that edge).
- out_ready is ignored when out_valid=0.

Test Plan:
- N=16, MSB=16, HALF=1, BITREV=0. Word k = {re=k, im=-(k)}, pulse fft_finish, out_ready=1 → 8 beats on consecutive cycles starting 2 cycles after the pulse. out_mag = k + (k>>1) (bin 3 → 4, bin 7 → 10). out_last only on bin 7; peak_valid pulses one cycle after that beat with peak_bin=7, peak_mag=10.
- Word 2 = {re=-128, im=-128}, word 5 = {re=3, im=-4}, rest 0 → bin2 mag=192, bin5 mag=5, peak_bin=2, peak_mag=192.
- Same frame with out_ready toggling 1010… → outputs stable across stalled cycles, no bin skipped or duplicated, 8 accepted beats total.
- Frame whose bins 1 and 6 both have mag 50, rest 0 → peak_bin=1. All-zero frame → peak_bin=0, peak_mag=0, peak_valid still pulses.
- BITREV=1, HALF=0, word w = {re=w, im=0} → beat k has out_mag = bitrev4(k) + 0 (beat 1 → 8, beat 3 → 12), 16 beats.
- Second fft_finish during STREAM → overrun=1, stream of first frame unchanged. Assert reset during beat 4 → out_valid=0, frame_ready=1, overrun=0 immediately (asynchronous); a new frame afterwards streams from bin 0.
